// File: rtl/exec_unit.sv
// exec_unit: ALU / branch-compare execution unit with an optional iterative multiply/divide path.
// Define MULDIV_EN to build the radix-2 MUL/DIV engine; without it, fun 19-26 report illegal.
module exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      fun,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_flg,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic signed [XLEN-1:0] op1_s, op2_s;
  logic [XLEN-1:0]        sum, iss_res;
  logic [SHW-1:0]         shamt;
  logic                   iss_br, iss_ill, start_calc;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign op1_s     = op1;
  assign op2_s     = op2;
  assign sum       = op1 + op2;
  assign shamt     = op2[SHW-1:0];

`ifdef MULDIV_EN
  logic [SHW-1:0]      cnt;
  logic                last, div_op, rem_op, sgn_div, ovf, a_sgn, b_sgn, a_neg, b_neg;
  logic                md_div, md_hi, md_rem, md_neg;
  logic [XLEN-1:0]     a_mag, b_mag, acc, lo, mcand, acc_nxt, lo_nxt, q_fix, r_fix, md_res;
  logic [XLEN:0]       add_w, rs_w, diff_w;
  logic [2*XLEN-1:0]   prod, prod_fix;

  assign div_op  = (fun >= 5'd23);
  assign rem_op  = (fun == 5'd25) || (fun == 5'd26);
  assign sgn_div = (fun == 5'd23) || (fun == 5'd25);
  assign ovf     = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign a_sgn   = (fun == 5'd20) || (fun == 5'd21) || sgn_div;
  assign b_sgn   = (fun == 5'd20) || sgn_div;
  assign a_neg   = a_sgn & op1[XLEN-1];
  assign b_neg   = b_sgn & op2[XLEN-1];
  assign a_mag   = a_neg ? '0 - op1 : op1;
  assign b_mag   = b_neg ? '0 - op2 : op2;
  assign last    = (cnt == SHW'(XLEN-1));

  // Engine works on magnitudes; sign is restored on the final iteration.
  always_comb begin
    add_w  = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    rs_w   = {acc, lo[XLEN-1]};
    diff_w = rs_w - {1'b0, mcand};
    if (md_div) begin
      acc_nxt = diff_w[XLEN] ? rs_w[XLEN-1:0] : diff_w[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ~diff_w[XLEN]};
    end else begin
      acc_nxt = add_w[XLEN:1];
      lo_nxt  = {add_w[0], lo[XLEN-1:1]};
    end
    prod     = {acc_nxt, lo_nxt};
    prod_fix = md_neg ? '0 - prod : prod;
    q_fix    = md_neg ? '0 - lo_nxt : lo_nxt;
    r_fix    = md_neg ? '0 - acc_nxt : acc_nxt;
    if (md_div) md_res = md_rem ? r_fix : q_fix;
    else        md_res = md_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (accept)         cnt <= '0;
    else if (state == CALC)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= '0;
      lo     <= a_mag;
      mcand  <= b_mag;
      md_div <= div_op;
      md_hi  <= (fun != 5'd19);
      md_rem <= rem_op;
      md_neg <= rem_op ? a_neg : (a_neg ^ b_neg);
    end else if (state == CALC) begin
      acc <= acc_nxt;
      lo  <= lo_nxt;
    end
  end
`endif

  always_comb begin
    iss_res    = '0;
    iss_br     = 1'b0;
    iss_ill    = 1'b0;
    start_calc = 1'b0;
    case (fun)
      5'd0:  iss_res = '0;
      5'd1:  iss_res = sum;
      5'd2:  iss_res = op1 - op2;
      5'd3:  iss_res = op1 & op2;
      5'd4:  iss_res = op1 | op2;
      5'd5:  iss_res = op1 ^ op2;
      5'd6:  iss_res = op1 << shamt;
      5'd7:  iss_res = op1 >> shamt;
      5'd8:  iss_res = op1_s >>> shamt;
      5'd9:  iss_res = {{(XLEN-1){1'b0}}, op1_s < op2_s};
      5'd10: iss_res = {{(XLEN-1){1'b0}}, op1 < op2};
      5'd11: iss_res = {sum[XLEN-1:1], 1'b0};
      5'd12: iss_res = op1;
      5'd13: iss_br  = (op1 == op2);
      5'd14: iss_br  = (op1 != op2);
      5'd15: iss_br  = (op1_s < op2_s);
      5'd16: iss_br  = (op1_s >= op2_s);
      5'd17: iss_br  = (op1 < op2);
      5'd18: iss_br  = (op1 >= op2);
`ifdef MULDIV_EN
      5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26: begin
        if (div_op && (op2 == '0))    iss_res = rem_op ? op1 : '1;
        else if (sgn_div && ovf)      iss_res = rem_op ? '0 : op1;
        else                          start_calc = 1'b1;
      end
`endif
      default: iss_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = start_calc ? CALC : DONE;
`ifdef MULDIV_EN
      CALC: if (last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result registers: loaded at accept, or at the end of an iterative op
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      br_flg  <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      result  <= iss_res;
      br_flg  <= iss_br;
      illegal <= iss_ill;
    end
`ifdef MULDIV_EN
    else if ((state == CALC) && last) begin
      result <= md_res;
    end
`endif
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter: SHW, $clog2(XLEN), shift-amount width.
REQ-003 SHALL have ports, one per line as follows.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  unit accepts request.
- fun  input  5  operation code (REQ-006).
- op1  input  XLEN  operand 1.
- op2  input  XLEN  operand 2.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  ALU/MUL/DIV result.
- br_flg  output  1  branch-taken flag, valid with out_valid.
- illegal  output  1  unsupported fun seen, valid with out_valid.
- busy  output  1  state != IDLE.

Function
REQ-004 SHALL implement states IDLE, CALC, DONE; transfer on in_valid & in_ready; in_ready = (state == IDLE).
REQ-005 SHALL register fun, op1, op2 on accept; inputs ignored outside IDLE.
REQ-006 SHALL decode fun: 0 X, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 JALR, 12 COPY1, 13 BEQ, 14 BNE, 15 BLT, 16 BGE, 17 BLTU, 18 BGEU, 19 MUL, 20 MULH, 21 MULHSU, 22 MULHU, 23 DIV, 24 DIVU, 25 REM, 26 REMU; 27-31 illegal.
REQ-007 Single-cycle ops (0-18) SHALL go IDLE->DONE; out_valid asserted the cycle after accept.
REQ-008 Shifts SHALL use op2[SHW-1:0]; SLT/SLTU result zero-extended 0/1; JALR = (op1+op2) with bit 0 cleared; COPY1 = op1; X gives 0; all arithmetic modulo 2^XLEN.
REQ-009 Branch ops (13-18) SHALL set br_flg per compare and result = 0; all other ops SHALL give br_flg = 0.
REQ-010 MUL/DIV ops SHALL go IDLE->CALC, iterate one bit per cycle for exactly XLEN cycles (radix-2 shift-add / restoring divide), then DONE; out_valid asserted XLEN+1 cycles after accept.
REQ-011 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-012 Divide by zero SHALL bypass CALC (DONE next cycle): DIV/DIVU quotient all-ones, REM/REMU = op1.
REQ-013 Signed overflow (op1 = -2^(XLEN-1), op2 = -1) SHALL bypass CALC: DIV = op1, REM = 0.
REQ-014 Illegal fun SHALL go to DONE next cycle with illegal = 1, result = 0, br_flg = 0.
REQ-015 DONE SHALL hold result, br_flg, illegal stable until out_valid & out_ready, then go to IDLE; no new accept in that same cycle.
REQ-016 out_valid = (state == DONE); busy = (state != IDLE).

Reset
REQ-017 rst high at a clock edge SHALL force state IDLE, result 0, br_flg 0, illegal 0, iteration counter 0, out_valid 0, in_ready 1 next cycle.
REQ-018 rst during CALC or DONE SHALL abort the operation; no result is ever presented for it.

Configuration
REQ-019 Macro MULDIV_EN defined: REQ-010..REQ-013 apply.
REQ-020 MULDIV_EN undefined: fun 19-26 SHALL be treated as illegal per REQ-014, no CALC state logic or iteration counter synthesised, in_ready timing otherwise unchanged.

Verification
REQ-021 ADD op1=0x7FFFFFFF op2=1 (XLEN=32) -> out_valid 1 cycle after accept, result 0x80000000, br_flg 0.
REQ-022 BGE op1=0xFFFFFFFF op2=1 -> br_flg 0; BGEU same operands -> br_flg 1; result 0 both.
REQ-023 MULH op1=0x80000000 op2=0x80000000 (MULDIV_EN) -> out_valid exactly 33 cycles after accept, result 0x40000000; out_ready held low 5 cycles -> result stable, in_ready 0.
REQ-024 DIV op1=0x80000000 op2=0xFFFFFFFF -> result 0x80000000 after 1 cycle; DIVU op1=7 op2=0 -> 0xFFFFFFFF after 1 cycle; REMU op1=7 op2=0 -> 7.
REQ-025 DIVU op1=100 op2=7, rst pulsed at cycle 10 of CALC -> out_valid never asserted for it; next ADD 2+3 -> 5 after 1 cycle.
REQ-026 Build without MULDIV_EN, fun=19 -> illegal 1, result 0, out_valid 1 cycle after accept; XLEN=64 SRA op1=0x8000000000000000 op2=63 -> all-ones.
